// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared constants and types for the UART receiver with FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int ACC_W = 20;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  // odd_ones is the XOR of all data bits and the received parity bit
  function automatic logic parity_err(input logic [1:0] mode, input logic odd_ones);
    if (mode == PAR_EVEN)     return odd_ones;
    else if (mode == PAR_ODD) return ~odd_ones;
    else                      return 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : show-ahead synchronous FIFO with overflow event output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, do_pop, do_push;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = rd_en && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    do_push  = wr_en && (!full || do_pop);
    ovf      = wr_en && full && !do_pop;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rd_valid = !empty;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo : 8x-oversampling UART receiver feeding a receive FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int INCR       = 3221,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 rd_en,
  input  logic                 clr_status,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_perr,
  output logic                 rd_ferr,
  output logic                 rd_valid,
  output logic                 overrun,
  output logic                 rx_busy
);

  import uart_pkg::*;

  localparam logic [1:0] PAR_MODE = 2'(PARITY);

  logic [ACC_W:0] acc_q, acc_d;
  logic [1:0]     sync_q, sync_d;
  logic           overrun_q, overrun_d;
  logic           tick, din, sample, fifo_ovf;

  rx_state_e            state_q;
  logic [2:0]           tick_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q, wait_high_q, push_q;
  logic [DATA_BITS+1:0] push_data_q;
  logic [DATA_BITS+1:0] fifo_dout;

  always_comb begin
    acc_d     = {1'b0, acc_q[ACC_W-1:0]} + (ACC_W+1)'(INCR);
    sync_d    = {sync_q[0], rxd};
    overrun_d = (overrun_q & ~clr_status) | fifo_ovf;
    tick      = acc_q[ACC_W];
    din       = sync_q[1];
    sample    = tick && (tick_cnt_q == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sync_q    <= 2'b11;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sync_q    <= sync_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wait_high_q <= 1'b1;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (din) wait_high_q <= 1'b0;
          if (tick && !din && !wait_high_q) begin
            state_q    <= ST_START;
            tick_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt_q == 3'd3) begin
              tick_cnt_q <= '0;
              if (din) begin
                state_q <= ST_IDLE;
              end else begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
                perr_q    <= 1'b0;
                ferr_q    <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 3'd1;
          if (sample) begin
            shift_q <= {din, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 4'(DATA_BITS-1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PAR_MODE != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        ST_PAR: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 3'd1;
          if (sample) begin
            perr_q  <= parity_err(PAR_MODE, (^shift_q) ^ din);
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) tick_cnt_q <= tick_cnt_q + 3'd1;
          if (sample) begin
            if (bit_cnt_q == 4'(STOP_BITS-1)) begin
              push_q      <= 1'b1;
              push_data_q <= {ferr_q | ~din, perr_q, shift_q};
              // a low final stop bit would otherwise look like a new start bit
              wait_high_q <= ~din;
              state_q     <= ST_IDLE;
            end else begin
              ferr_q    <= ferr_q | ~din;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push_q),
    .wr_data  (push_data_q),
    .rd_en    (rd_en),
    .rd_data  (fifo_dout),
    .rd_valid (rd_valid),
    .ovf      (fifo_ovf)
  );

  assign rd_data = fifo_dout[DATA_BITS-1:0];
  assign rd_perr = fifo_dout[DATA_BITS];
  assign rd_ferr = fifo_dout[DATA_BITS+1];
  assign overrun = overrun_q;
  assign rx_busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-002 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked, legal 1 or 2.
REQ-004 Parameter INCR, default 3221: 20-bit phase-accumulator increment; tick8x frequency = f_clk*INCR/2**20 (3221 gives 19200 bit/s at 50 MHz).
REQ-005 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of 2, legal 2..16.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 Port rxd, input, 1: serial data, idle high, asynchronous to clk.
REQ-009 Port rd_en, input, 1: pop the FIFO head this cycle.
REQ-010 Port clr_status, input, 1: clear the sticky overrun flag.
REQ-011 Port rd_data, output, DATA_BITS: FIFO head data, show-ahead.
REQ-012 Port rd_perr, output, 1: parity error flag stored with the head entry.
REQ-013 Port rd_ferr, output, 1: framing error flag stored with the head entry.
REQ-014 Port rd_valid, output, 1: FIFO not empty.
REQ-015 Port overrun, output, 1: sticky flag; a frame was lost because the FIFO was full.
REQ-016 Port rx_busy, output, 1: receiver is not in IDLE.

Function
REQ-017 21-bit accumulator adds INCR to its low 20 bits every clk; bit 20 is the one-cycle tick8x pulse.
REQ-018 rxd passes a 2-FF clk synchroniser, reset to 1; its output is din.
REQ-019 State machine has states IDLE, START, DATA, PAR, STOP.
REQ-020 IDLE: din = 0 on a tick8x moves to START and clears the tick counter.
REQ-021 START: on the 4th tick8x, din = 1 returns to IDLE (glitch, nothing pushed); din = 0 moves to DATA.
REQ-022 Every following bit is sampled on each 8th tick8x after the start-bit mid-sample.
REQ-023 DATA shifts DATA_BITS samples LSB-first, then moves to PAR if PARITY != 0, otherwise to STOP.
REQ-024 PAR samples one bit; perr = 1 when the XOR of data and parity bit is 1 (even) or 0 (odd).
REQ-025 STOP samples STOP_BITS bits; ferr = 1 if any stop sample = 0.
REQ-026 On the last stop sample, {ferr, perr, data} is pushed in that cycle and the state returns to IDLE; if ferr = 1 and din = 0, IDLE waits for din = 1 before accepting a new start.
REQ-027 A frame reaches rd_valid 1 clk after the push cycle.
REQ-028 rd_en with rd_valid = 1 pops; rd_en with rd_valid = 0 is ignored.
REQ-029 Push while full and not popping: frame discarded, FIFO unchanged, overrun set to 1.
REQ-030 Push and pop in the same cycle when full: both succeed, occupancy unchanged, overrun not set.
REQ-031 clr_status clears overrun; if clr_status coincides with a new overrun event, overrun stays 1.
REQ-032 FIFO pointers are log2(FIFO_DEPTH)+1 bits; pointer MSBs differ when full; pointers wrap without error.

Reset
REQ-033 rst_n = 0 asynchronously sets: state IDLE, accumulator 0, synchroniser 11, FIFO empty, rd_valid 0, rd_data 0, rd_perr 0, rd_ferr 0, overrun 0, rx_busy 0.
REQ-034 Reset asserted mid-frame discards the partial frame; the first start bit is accepted only after din has been seen high.

Structure
REQ-035 Parity-mode encodings, state encodings and the accumulator width (20) are constants in the shared package uart_pkg.
REQ-036 FIFO is one sub-module, sync_fifo, parameterised by width (DATA_BITS+2) and depth.

Verification
REQ-037 INCR = 206144, 8N1, byte 0xA5 -> rd_valid rises with rd_data = 0xA5, perr = 0, ferr = 0.
REQ-038 PARITY = 1, 7 data bits, 0x41 sent with wrong parity bit 1 -> rd_data = 0x41, rd_perr = 1.
REQ-039 Stop bit driven 0 on 0x3C -> rd_ferr = 1; no new frame until rxd returns high.
REQ-040 1.5-tick low glitch on idle rxd -> returns to IDLE, rd_valid stays 0.
REQ-041 FIFO_DEPTH = 4, five frames sent with no reads -> first four read back in order, overrun = 1; clr_status -> overrun = 0.
REQ-042 rst_n pulsed low mid-DATA -> all outputs at reset values; the next full frame 0x5A is received correctly.
